// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and period of an external PWM pin in
// prescaled ticks. Same 8-bit divider semantics as the PWM output driver.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   pwm_in         external PWM pin, asynchronous to clock
//   div            prescaler (0 disables the block and clears the results)
//   high_count     last captured high time, ticks
//   period_count   last captured period, ticks
//   capture_valid  one-cycle pulse when high_count/period_count update
//   no_signal      sticky flag: no edge for a full 16-bit period count
//
// Build option: define PWM_CAP_GLITCH_FILTER_EN to insert a glitch filter
// (FILTER_LEN consecutive equal samples, legal 2..15) after the synchronizer.
module pwm_capture
`ifdef PWM_CAP_GLITCH_FILTER_EN
#(
    parameter int unsigned FILTER_LEN = 4
)
`endif
(
    input  logic        clock,
    input  logic        reset,
    input  logic        pwm_in,
    input  logic [7:0]  div,
    output logic [15:0] high_count,
    output logic [15:0] period_count,
    output logic        capture_valid,
    output logic        no_signal
);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    state_t      state, state_n;
    logic        sync1, sync2, lvl, lvl_d;
    logic        rise, fall, tick, timeout;
    logic [7:0]  presc, div_act;
    logic [15:0] hi_cnt, per_cnt, hi_n, per_n, hc_n, pc_n;
    logic        cv_n, ns_n;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != '1)) ? v + 16'd1 : v;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic [3:0] fcnt;

    // Level flips on the FILTER_LEN-th consecutive sample that disagrees.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lvl  <= 1'b0;
            fcnt <= '0;
        end else if (sync2 != lvl) begin
            if (fcnt == 4'(FILTER_LEN - 1)) begin
                lvl  <= sync2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 4'd1;
            end
        end else begin
            fcnt <= '0;
        end
    end
`else
    always_comb lvl = sync2;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lvl_d <= 1'b0;
        else       lvl_d <= lvl;
    end

    always_comb begin
        rise    = lvl & ~lvl_d;
        fall    = ~lvl & lvl_d;
        tick    = (div_act != '0) && (presc == div_act - 8'd1);
        timeout = tick && (per_cnt == '1) && !rise && !fall;
    end

    // div_act holds the divider in use; a new div value is only taken at a
    // wrap (or a rise, which also restarts the prescaler), so a divider
    // change never produces a truncated tick interval. div_act == 0 means
    // the block has just left IDLE and must pick up div immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            div_act <= '0;
        end else if (div == '0) begin
            presc   <= '0;
            div_act <= '0;
        end else if (rise || tick || (div_act == '0)) begin
            presc   <= '0;
            div_act <= div;
        end else begin
            presc   <= presc + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hi_cnt        <= '0;
            per_cnt       <= '0;
            high_count    <= '0;
            period_count  <= '0;
            capture_valid <= 1'b0;
            no_signal     <= 1'b0;
        end else begin
            state         <= state_n;
            hi_cnt        <= hi_n;
            per_cnt       <= per_n;
            high_count    <= hc_n;
            period_count  <= pc_n;
            capture_valid <= cv_n;
            no_signal     <= ns_n;
        end
    end

    always_comb begin
        state_n = state;
        hi_n    = hi_cnt;
        per_n   = per_cnt;
        hc_n    = high_count;
        pc_n    = period_count;
        cv_n    = 1'b0;
        ns_n    = no_signal;
        if (div == '0) begin
            state_n = IDLE;
            hi_n    = '0;
            per_n   = '0;
            hc_n    = '0;
            pc_n    = '0;
            ns_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = ARM;
                    hi_n    = '0;
                    per_n   = '0;
                    hc_n    = '0;
                    pc_n    = '0;
                    ns_n    = 1'b0;
                end
                ARM: begin
                    if (rise) begin
                        state_n = HIGH;
                        hi_n    = '0;
                        per_n   = '0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_n    = sat_inc(hi_cnt, tick);
                        per_n   = sat_inc(per_cnt, tick);
                        state_n = LOW;
                    end else if (timeout) begin
                        ns_n    = 1'b1;
                        state_n = ARM;
                        hi_n    = '0;
                        per_n   = '0;
                    end else begin
                        hi_n    = sat_inc(hi_cnt, tick);
                        per_n   = sat_inc(per_cnt, tick);
                    end
                end
                LOW: begin
                    if (rise) begin
                        hc_n    = hi_cnt;
                        pc_n    = sat_inc(per_cnt, tick);
                        cv_n    = 1'b1;
                        ns_n    = 1'b0;
                        hi_n    = '0;
                        per_n   = '0;
                        state_n = HIGH;
                    end else if (timeout) begin
                        ns_n    = 1'b1;
                        state_n = ARM;
                        hi_n    = '0;
                        per_n   = '0;
                    end else begin
                        per_n   = sat_inc(per_cnt, tick);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int unsigned LAT  = 7;
    localparam int unsigned MINW = 6;
`else
    localparam int unsigned LAT  = 3;
    localparam int unsigned MINW = 2;
`endif
    localparam int unsigned NONE = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [7:0]  div;
    logic [15:0] high_count, period_count;
    logic        capture_valid, no_signal;

    pwm_capture dut (
        .clock(clock), .reset(reset), .pwm_in(pwm_in), .div(div),
        .high_count(high_count), .period_count(period_count),
        .capture_valid(capture_valid), .no_signal(no_signal)
    );

    always #5 clock = ~clock;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned now   = 0;

    // Event-level reference: expected results are computed from edge
    // timestamps (floor of interval / div), not from any per-cycle counter.
    typedef struct {
        int unsigned t;
        int          kind;   // 0 = capture, 1 = clear
        logic [15:0] hc;
        logic [15:0] pc;
    } ev_t;
    ev_t         evq[$];
    bit          m_lv = 0, m_armed = 0;
    int unsigned m_div = 0, last_rise = 0, last_fall = 0;
    int unsigned timeout_at = NONE;
    logic [15:0] p_hc = '0, p_pc = '0;
    bit          p_ns = 0, exp_cv = 0;

    typedef struct {
        int unsigned d, h, p;
        logic [15:0] ehc, epc;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [15:0] sat16(input int unsigned v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, now, act, exp);
        end
    endtask

    task automatic model_tick();
        ev_t e;
        exp_cv = 0;
        while (evq.size() > 0 && evq[0].t <= now) begin
            e = evq.pop_front();
            if (e.kind == 0) begin
                p_hc = e.hc; p_pc = e.pc; p_ns = 0;
                if (e.t == now) exp_cv = 1;
            end else begin
                p_hc = '0; p_pc = '0; p_ns = 0;
            end
        end
        if (timeout_at == now) begin
            p_ns = 1; m_armed = 0; timeout_at = NONE;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        now++;
        model_tick();
        check_eq("cycle", {30'd0, capture_valid, high_count, period_count, no_signal},
                 {30'd0, exp_cv, p_hc, p_pc, p_ns});
    endtask

    task automatic model_rise();
        ev_t e;
        if (m_div == 0) return;
        if (m_armed) begin
            e.t = now + LAT; e.kind = 0;
            e.hc = sat16((last_fall - last_rise) / m_div);
            e.pc = sat16((now - last_rise) / m_div);
            evq.push_back(e);
        end
        m_armed    = 1;
        last_rise  = now;
        timeout_at = now + LAT + 65536 * m_div;
    endtask

    task automatic set_pin(input logic v);
        pwm_in = v;
        if (v && !m_lv) model_rise();
        if (!v && m_lv) last_fall = now;
        m_lv = v;
    endtask

    task automatic set_div(input int unsigned d);
        ev_t e;
        div = 8'(d);
        if (d == 0) begin
            e.t = now + 1; e.kind = 1; e.hc = '0; e.pc = '0;
            evq.push_back(e);
            m_armed = 0; timeout_at = NONE;
        end
        m_div = d;
    endtask

    task automatic hit_reset();
        reset = 1'b1;
        #1;
        evq.delete();
        m_armed = 0; m_lv = 0; timeout_at = NONE;
        p_hc = '0; p_pc = '0; p_ns = 0;
        check_eq("async_reset", {capture_valid, high_count, period_count, no_signal}, '0);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        if (pwm_in && !m_lv) begin
            m_lv = 1;
            model_rise();
        end
    endtask

    task automatic run_wave(input int unsigned h, input int unsigned p, input int unsigned n);
        repeat (n) begin
            set_pin(1'b1);
            repeat (h) step();
            set_pin(1'b0);
            repeat (p - h) step();
        end
    endtask

    task automatic restart(input int unsigned d);
        set_div(0);
        repeat (4) step();
        set_div(d);
        repeat (2) step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned h, l, d, waited;
        tbl[0] = '{d: 1,   h: 30,  p: 100, ehc: 16'd30, epc: 16'd100};
        tbl[1] = '{d: 4,   h: 40,  p: 160, ehc: 16'd10, epc: 16'd40};
        tbl[2] = '{d: 4,   h: 41,  p: 163, ehc: 16'd10, epc: 16'd40};
        tbl[3] = '{d: 3,   h: 10,  p: 20,  ehc: 16'd3,  epc: 16'd6};
        tbl[4] = '{d: 7,   h: 6,   p: 13,  ehc: 16'd0,  epc: 16'd1};
        tbl[5] = '{d: 2,   h: 7,   p: 14,  ehc: 16'd3,  epc: 16'd7};
        tbl[6] = '{d: 255, h: 300, p: 600, ehc: 16'd1,  epc: 16'd2};

        reset = 1'b1; pwm_in = 1'b0; div = '0;
        repeat (2) step();
        check_eq("rst_hc", high_count, 0);
        check_eq("rst_pc", period_count, 0);
        check_eq("rst_cv", capture_valid, 0);
        check_eq("rst_ns", no_signal, 0);
        release_reset();
        repeat (2) step();

        // Table: fixed waveforms, constant expectations.
        foreach (tbl[i]) begin
            restart(tbl[i].d);
            run_wave(tbl[i].h, tbl[i].p, 4);
            set_pin(1'b1);
            repeat (LAT + 2) step();
            check_eq($sformatf("tbl%0d_hc", i), high_count, tbl[i].ehc);
            check_eq($sformatf("tbl%0d_pc", i), period_count, tbl[i].epc);
            check_eq($sformatf("tbl%0d_ns", i), no_signal, 0);
            set_pin(1'b0);
            repeat (8) step();
        end

        // Waveform change at div=4 without re-arming.
        restart(4);
        run_wave(40, 160, 3);
        run_wave(41, 163, 3);
        set_pin(1'b1);
        repeat (LAT + 2) step();
        check_eq("chg_hc", high_count, 10);
        check_eq("chg_pc", period_count, 40);

        // Timeout after captures, then recovery.
        restart(1);
        run_wave(30, 100, 3);
        set_pin(1'b1);
        repeat (30) step();
        set_pin(1'b0);
        waited = 0;
        while (!no_signal && waited < 70000) begin
            step();
            waited++;
        end
        check_eq("to_ns", no_signal, 1);
        check_eq("to_hc", high_count, 30);
        check_eq("to_pc", period_count, 100);
        set_pin(1'b1);
        repeat (30) step();
        set_pin(1'b0);
        repeat (70) step();
        check_eq("arm_keeps_ns", no_signal, 1);
        set_pin(1'b1);
        repeat (LAT + 1) step();
        check_eq("recov_ns", no_signal, 0);
        check_eq("recov_hc", high_count, 30);
        check_eq("recov_pc", period_count, 100);
        repeat (29 - LAT) step();
        set_pin(1'b0);
        repeat (70) step();

        // div forced to 0 mid-period, then restored.
        run_wave(30, 100, 2);
        set_pin(1'b1);
        repeat (30) step();
        set_pin(1'b0);
        repeat (20) step();
        set_div(0);
        step();
        check_eq("div0_hc", high_count, 0);
        check_eq("div0_pc", period_count, 0);
        check_eq("div0_cv", capture_valid, 0);
        repeat (5) step();
        set_div(1);
        repeat (2) step();
        run_wave(30, 100, 1);
        set_pin(1'b1);
        repeat (LAT) step();
        check_eq("div1_cv", capture_valid, 1);
        check_eq("div1_hc", high_count, 30);
        check_eq("div1_pc", period_count, 100);

        // Reset while the pin is high mid-HIGH.
        repeat (10) step();
        hit_reset();
        repeat (3) step();
        release_reset();
        repeat (20) step();
        set_pin(1'b0);
        repeat (60) step();
        set_pin(1'b1);
        repeat (LAT) step();
        check_eq("rel_cv", capture_valid, 1);
        check_eq("rel_hc", high_count, 20);
        check_eq("rel_pc", period_count, 80);
        repeat (10) step();
        set_pin(1'b0);
        repeat (10) step();

`ifdef PWM_CAP_GLITCH_FILTER_EN
        restart(1);
        run_wave(30, 100, 2);
        set_pin(1'b1);
        repeat (30) step();
        set_pin(1'b0);
        repeat (30) step();
        pwm_in = 1'b1;
        repeat (2) step();
        pwm_in = 1'b0;
        repeat (38) step();
        set_pin(1'b1);
        repeat (LAT + 1) step();
        check_eq("glitch_hc", high_count, 30);
        check_eq("glitch_pc", period_count, 100);
        repeat (29 - LAT) step();
        set_pin(1'b0);
        repeat (30) step();
        set_pin(1'b1);
        repeat (6) step();
        set_pin(1'b0);
        repeat (34) step();
        set_pin(1'b1);
        repeat (LAT + 1) step();
        check_eq("pulse_hc", high_count, 6);
        check_eq("pulse_pc", period_count, 40);
        set_pin(1'b0);
        repeat (10) step();
`endif

        // Randomized waveforms against the event-level reference.
        for (int c = 0; c < 10; c++) begin
            d = $urandom_range(1, 6);
            restart(d);
            repeat (6) begin
                h = $urandom_range(MINW, 40);
                l = $urandom_range(MINW, 40);
                run_wave(h, h + l, 1);
            end
            set_pin(1'b1);
            repeat (LAT + 2) step();
            set_pin(1'b0);
            repeat (8) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
